// File: rtl/univ_shift_register.sv
//------------------------------------------------------------------------------
// Module      : univ_shift_register
// Description : Universal shift register (hold / shift left / shift right /
//               parallel load) with saturating shift counter and frame pulse.
//               Optional rotate mode via macro UNIV_SHIFT_REGISTER_ROTATE_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module univ_shift_register #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pin,
    input  logic             rot,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_done
);

    localparam logic [1:0]    C_MODE_HOLD  = 2'b00;
    localparam logic [1:0]    C_MODE_LEFT  = 2'b01;
    localparam logic [1:0]    C_MODE_RIGHT = 2'b10;
    localparam logic [1:0]    C_MODE_LOAD  = 2'b11;
    localparam logic [CW-1:0] C_CNT_FULL   = CW'(WIDTH);
    localparam logic [CW-1:0] C_CNT_LAST   = CW'(WIDTH - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             w_fill_r;
    logic             w_fill_l;
    logic             w_shift;

`ifdef UNIV_SHIFT_REGISTER_ROTATE_EN
    assign w_fill_r = rot ? q_q[WIDTH-1] : sin_r;
    assign w_fill_l = rot ? q_q[0]       : sin_l;
`else
    logic w_rot_unused;
    assign w_rot_unused = rot;
    assign w_fill_r     = sin_r;
    assign w_fill_l     = sin_l;
`endif

    always_comb begin
        q_d     = q_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        w_shift = 1'b0;
        if (en) begin
            case (mode)
                C_MODE_HOLD:  ;
                C_MODE_LEFT: begin
                    q_d     = {q_q[WIDTH-2:0], w_fill_r};
                    w_shift = 1'b1;
                end
                C_MODE_RIGHT: begin
                    q_d     = {w_fill_l, q_q[WIDTH-1:1]};
                    w_shift = 1'b1;
                end
                C_MODE_LOAD: begin
                    q_d   = pin;
                    cnt_d = '0;
                end
                default: ;
            endcase
            // Counter saturates at WIDTH; the pulse fires only on the final step
            if (w_shift && (cnt_q < C_CNT_FULL)) begin
                cnt_d  = cnt_q + CW'(1);
                done_d = (cnt_q == C_CNT_LAST);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign q          = q_q;
    assign sout_l     = q_q[WIDTH-1];
    assign sout_r     = q_q[0];
    assign shift_cnt  = cnt_q;
    assign frame_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_univ_shift_register.sv
//------------------------------------------------------------------------------
// Module      : tb_univ_shift_register
// Description : Directed vector bench for univ_shift_register (WIDTH=8).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_univ_shift_register;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] mode;
        logic       sin_r;
        logic       sin_l;
        logic [7:0] pin;
        logic       rot;
        logic [7:0] exp_q;
        logic [3:0] exp_cnt;
        logic       exp_done;
        string      name;
    } vec_t;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pin;
    logic             rot;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic [CW-1:0]    shift_cnt;
    logic             frame_done;

    int n_vec  = 0;
    int n_fail = 0;

    vec_t vecs[$];

    univ_shift_register #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .pin        (pin),
        .rot        (rot),
        .q          (q),
        .sout_l     (sout_l),
        .sout_r     (sout_r),
        .shift_cnt  (shift_cnt),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic e, input logic [1:0] m,
                                input logic sr, input logic sl, input logic [7:0] p,
                                input logic rt, input logic [7:0] eq,
                                input logic [3:0] ec, input logic ed, input string nm);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.sin_r = sr; v.sin_l = sl; v.pin = p;
        v.rot = rt; v.exp_q = eq; v.exp_cnt = ec; v.exp_done = ed; v.name = nm;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] eq,
                         input logic [3:0] ec, input logic ed);
        n_vec++;
        if (q !== eq || shift_cnt !== ec || frame_done !== ed ||
            sout_l !== eq[7] || sout_r !== eq[0]) begin
            n_fail++;
            $display("FAIL %s: got q=%h cnt=%0d done=%b sout_l=%b sout_r=%b, expected q=%h cnt=%0d done=%b sout_l=%b sout_r=%b",
                     nm, q, shift_cnt, frame_done, sout_l, sout_r,
                     eq, ec, ed, eq[7], eq[0]);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic sr, input logic sl, input logic [7:0] p,
                         input logic rt);
        rst = r; en = e; mode = m; sin_r = sr; sin_l = sl; pin = p; rot = rt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] eq;
        logic [7:0] rot_l_q;
        logic [7:0] rot_r_q;

`ifdef UNIV_SHIFT_REGISTER_ROTATE_EN
        rot_l_q = 8'h03;
        rot_r_q = 8'h81;
`else
        rot_l_q = 8'h02;
        rot_r_q = 8'h01;
`endif

        // reset with arbitrary other inputs
        vecs.push_back(mk(0, 1, 2'b11, 1, 1, 8'hFF, 1, 8'h00, 0, 0, "reset"));
        // parallel in, serial out on the left
        vecs.push_back(mk(1, 1, 2'b11, 0, 0, 8'hA5, 0, 8'hA5, 0, 0, "load_A5"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'h4A, 1, 0, "piso_1"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'h94, 2, 0, "piso_2"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'h28, 3, 0, "piso_3"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'h50, 4, 0, "piso_4"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'hA0, 5, 0, "piso_5"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'h40, 6, 0, "piso_6"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'h80, 7, 0, "piso_7"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'h00, 8, 1, "piso_8"));
        vecs.push_back(mk(1, 1, 2'b00, 1, 1, 8'hFF, 0, 8'h00, 8, 0, "hold_after_frame"));
        // serial in from the left, shifting right
        vecs.push_back(mk(1, 1, 2'b11, 0, 0, 8'h00, 0, 8'h00, 0, 0, "load_00"));
        vecs.push_back(mk(1, 1, 2'b10, 0, 1, 8'h00, 0, 8'h80, 1, 0, "sipo_1"));
        vecs.push_back(mk(1, 1, 2'b10, 0, 1, 8'h00, 0, 8'hC0, 2, 0, "sipo_2"));
        vecs.push_back(mk(1, 1, 2'b10, 0, 0, 8'h00, 0, 8'h60, 3, 0, "sipo_3"));
        vecs.push_back(mk(1, 1, 2'b10, 0, 0, 8'h00, 0, 8'h30, 4, 0, "sipo_4"));
        vecs.push_back(mk(1, 1, 2'b10, 0, 1, 8'h00, 0, 8'h98, 5, 0, "sipo_5"));
        vecs.push_back(mk(1, 1, 2'b10, 0, 0, 8'h00, 0, 8'h4C, 6, 0, "sipo_6"));
        vecs.push_back(mk(1, 1, 2'b10, 0, 1, 8'h00, 0, 8'hA6, 7, 0, "sipo_7"));
        vecs.push_back(mk(1, 1, 2'b10, 0, 0, 8'h00, 0, 8'h53, 8, 1, "sipo_8"));
        vecs.push_back(mk(1, 1, 2'b10, 0, 0, 8'h00, 0, 8'h29, 8, 0, "sipo_9_saturated"));
        vecs.push_back(mk(1, 1, 2'b01, 1, 0, 8'h00, 0, 8'h53, 8, 0, "left_saturated"));
        // enable gating
        vecs.push_back(mk(1, 1, 2'b11, 0, 0, 8'h3C, 0, 8'h3C, 0, 0, "load_3C"));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(1, 0, 2'b01, 1, 1, 8'hFF, 0, 8'h3C, 0, 0, "en_off"));
        // reset in the middle of a frame
        vecs.push_back(mk(1, 1, 2'b11, 0, 0, 8'hFF, 0, 8'hFF, 0, 0, "load_FF"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'hFE, 1, 0, "pre_rst_1"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'hFC, 2, 0, "pre_rst_2"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'hF8, 3, 0, "pre_rst_3"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'hF0, 4, 0, "pre_rst_4"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'hE0, 5, 0, "pre_rst_5"));
        vecs.push_back(mk(0, 1, 2'b01, 1, 1, 8'hAA, 0, 8'h00, 0, 0, "mid_rst"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'h00, 1, 0, "post_rst_1"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'h00, 2, 0, "post_rst_2"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 0, 8'h00, 3, 0, "post_rst_3"));
        // rotate request (honoured only when the rotate build option is on)
        vecs.push_back(mk(1, 1, 2'b11, 0, 0, 8'h81, 0, 8'h81, 0, 0, "load_81"));
        vecs.push_back(mk(1, 1, 2'b01, 0, 0, 8'h00, 1, rot_l_q, 1, 0, "rot_left"));
        vecs.push_back(mk(1, 1, 2'b10, 0, 0, 8'h00, 1, rot_r_q, 2, 0, "rot_right"));

        rst = 1'b0; en = 1'b0; mode = 2'b00; sin_r = 1'b0; sin_l = 1'b0;
        pin = '0; rot = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].sin_r,
                  vecs[i].sin_l, vecs[i].pin, vecs[i].rot);
            check(vecs[i].name, vecs[i].exp_q, vecs[i].exp_cnt, vecs[i].exp_done);
        end

        // frame completion with idle (en=0) cycles around the final shift
        drive(1, 1, 2'b11, 0, 0, 8'h00, 0);
        check("seq_load", 8'h00, 0, 0);
        for (int i = 1; i <= 7; i++) begin
            drive(1, 1, 2'b01, 1, 0, 8'h00, 0);
            eq = 8'((1 << i) - 1);
            check("seq_shift", eq, 4'(i), 0);
        end
        drive(1, 0, 2'b01, 1, 0, 8'h00, 0);
        check("seq_idle_before_last", 8'h7F, 7, 0);
        drive(1, 1, 2'b01, 1, 0, 8'h00, 0);
        check("seq_last_shift", 8'hFF, 8, 1);
        drive(1, 0, 2'b01, 1, 0, 8'h00, 0);
        check("seq_idle_after_last", 8'hFF, 8, 0);
        drive(1, 1, 2'b11, 0, 0, 8'h12, 0);
        check("seq_reload", 8'h12, 0, 0);
        drive(1, 1, 2'b10, 0, 1, 8'h00, 0);
        check("seq_after_reload", 8'h89, 1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/univ_shift_register.md
UNIV_SHIFT_REGISTER -- requirements
Module: univ_shift_register

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the register width in bits (legal range 2..64).
REQ-002 The block SHALL have parameter CW, default $clog2(WIDTH+1), meaning the shift-count width (derived; not overridden).
REQ-003 The block SHALL have port clk  input  1  system clock (all state on rising edge).
REQ-004 The block SHALL have port rst  input  1  reset: synchronous and active-low.
REQ-005 The block SHALL have port en  input  1  operation enable, sampled on each rising clk.
REQ-006 The block SHALL have port mode  input  2  operation select: 00 hold, 01 shift left, 10 shift right, 11 parallel load.
REQ-007 The block SHALL have port sin_r  input  1  serial in, enters q[0] on shift left.
REQ-008 The block SHALL have port sin_l  input  1  serial in, enters q[WIDTH-1] on shift right.
REQ-009 The block SHALL have port pin  input  WIDTH  parallel load data.
REQ-010 The block SHALL have port rot  input  1  rotate request (used only per REQ-027/028).
REQ-011 The block SHALL have port q  output  WIDTH  register contents.
REQ-012 The block SHALL have port sout_l  output  1  q[WIDTH-1], combinational from the register.
REQ-013 The block SHALL have port sout_r  output  1  q[0], combinational from the register.
REQ-014 The block SHALL have port shift_cnt  output  CW  shifts performed since last load, saturating at WIDTH.
REQ-015 The block SHALL have port frame_done  output  1  registered one-cycle pulse marking a completed frame.

Function
REQ-016 With rst high and en=1, on each rising clk the block SHALL perform the following mode actions:
- mode 00: q unchanged.
- mode 01: q <= {q[WIDTH-2:0], sin_r}.
- mode 10: q <= {sin_l, q[WIDTH-1:1]}.
- mode 11: q <= pin.
REQ-017 With en=0, q and shift_cnt SHALL hold and frame_done SHALL be 0 on the next edge.
REQ-018 Parallel load SHALL clear shift_cnt to 0 and drive frame_done to 0.
REQ-019 Each enabled shift (mode 01 or 10) SHALL increment shift_cnt by 1 while shift_cnt < WIDTH, and leave it at WIDTH otherwise.
REQ-020 frame_done SHALL be 1 for exactly the one cycle after the edge on which shift_cnt changes from WIDTH-1 to WIDTH, and 0 otherwise.
REQ-021 Shifts made while shift_cnt=WIDTH SHALL still move data but SHALL NOT re-assert frame_done; the next assertion requires a new load.
REQ-022 Mode 00 with en=1 SHALL leave shift_cnt unchanged and drive frame_done to 0.
REQ-023 Latency: q, shift_cnt and frame_done SHALL reflect an operation one clock after it is sampled; sout_l and sout_r SHALL follow q with no added latency.
REQ-024 The direction may change between cycles without restriction; mixed left and right shifts SHALL each count toward shift_cnt.

Reset
REQ-025 When rst=0 at a rising clk, the block SHALL set q=0, shift_cnt=0 and frame_done=0, with priority over en, mode and all other inputs.
REQ-026 A reset asserted mid-frame SHALL discard the partial frame; no frame_done SHALL follow from shifts made before the reset.

Configuration
REQ-027 With macro UNIV_SHIFT_REGISTER_ROTATE_EN defined and rot=1, shift left SHALL load q[0] from q[WIDTH-1], and shift right SHALL load q[WIDTH-1] from q[0]; sin_r and sin_l SHALL be ignored, and counting SHALL be unchanged.
REQ-028 With UNIV_SHIFT_REGISTER_ROTATE_EN undefined, rot SHALL be ignored, and shifts SHALL always use sin_r and sin_l.

Verification (WIDTH=8)
REQ-029 The bench SHALL cover a reset check: drive rst=0 for one edge with arbitrary inputs -> q=00, shift_cnt=0, frame_done=0.
REQ-030 The bench SHALL cover parallel-in serial-out: load pin=A5, then 8 left shifts with sin_r=0 -> sout_l sequence 1,0,1,0,0,1,0,1, q=00 after the 8th shift, frame_done=1 for exactly one cycle, shift_cnt=8.
REQ-031 The bench SHALL cover serial-in right shift: 8 right shifts with sin_l driving bits 1,1,0,0,1,0,1,0 -> q=53, and a 9th shift leaves shift_cnt=8 with no frame_done.
REQ-032 The bench SHALL cover enable gating: load 3C, then en=0 with mode 01 for 5 cycles -> q=3C and shift_cnt=0 throughout.
REQ-033 The bench SHALL cover reset mid-frame: load FF, 5 shifts, rst=0 for one edge, then 3 shifts -> q=00, shift_cnt=3, and frame_done never asserted.
REQ-034 The bench SHALL cover rotate (ROTATE_EN defined): load 81, rot=1, one left shift -> q=03; then one right shift -> q=81.
